// File: rtl/alu_operand_stage.sv
// Register file, PSR and registered A/B operand latch feeding the ALU.
// Reads forward same-edge write-back data so the ALU always sees the newest value.
module alu_operand_stage #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 16,
    parameter int R0_ZERO = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       RdestAddr,
    input  logic [3:0]       RsrcAddr,
    input  logic             ImmSel,
    input  logic             ImmSigned,
    input  logic [7:0]       Imm,
    input  logic             Stall,
    input  logic             WrEn,
    input  logic [3:0]       WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic             FlagsEn,
    input  logic [4:0]       FlagsIn,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [4:0]       PSR
);

    localparam logic [4:0] NREGS_W = 5'(NREGS);
    localparam logic       ZERO_R0 = (R0_ZERO != 0);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] imm_ext;
    logic             wr_ok;

    // R0 discards writes when hard-wired; indices past NREGS are ignored.
    assign wr_ok = WrEn
                 && !(ZERO_R0 && (WrAddr == 4'd0))
                 && ({1'b0, WrAddr} < NREGS_W);

    // Read port with same-edge write-back bypass.
    function automatic logic [WIDTH-1:0] rd(input logic [3:0] x);
        logic [WIDTH-1:0] v;
        v = '0;
        if (ZERO_R0 && (x == 4'd0)) begin
            v = '0;
        end else if (WrEn && (WrAddr == x)) begin
            v = WrData;
        end else if ({1'b0, x} < NREGS_W) begin
            v = regs[x];
        end
        return v;
    endfunction

    // Immediate extension and operand selection.
    always_comb begin
        imm_ext = {{(WIDTH-8){ImmSigned & Imm[7]}}, Imm};
        rd_a    = rd(RdestAddr);
        rd_b    = ImmSel ? imm_ext : rd(RsrcAddr);
    end

    // Register file: cleared by reset, otherwise written on write-back.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[WrAddr] <= WrData;
        end
    end

    // Operand latch: holds while stalled, loads new operands otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            A <= '0;
            B <= '0;
        end else if (!Stall) begin
            A <= rd_a;
            B <= rd_b;
        end
    end

    // Status register: loads ALU flags independent of stall and write-back.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            PSR <= '0;
        end else if (FlagsEn) begin
            PSR <= FlagsIn;
        end
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Register-file and operand-latch stage directly upstream of the 16-bit ALU.
- Holds the 16 general-purpose registers and the processor status register (PSR).
- Each cycle it presents registered A and B operands to the ALU, where B is either a register or an extended 8-bit immediate.
- Accepts ALU result write-back (C) and ALU flag write-back (ZCFNL).

Parameters:
- WIDTH, 16, data width of registers, A, B and WrData.
- NREGS, 16, number of general registers; address width fixed at 4 bits.
- R0_ZERO, 0, when 1 R0 always reads 0 and writes to R0 are discarded.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- RdestAddr  in  4  register index driving A.
- RsrcAddr  in  4  register index driving B when ImmSel=0.
- ImmSel  in  1  1: B sourced from Imm; 0: B from register RsrcAddr.
- ImmSigned  in  1  1: sign-extend Imm to 16 bits; 0: zero-extend.
- Imm  in  8  immediate field (ADDI/SUBI/CMPI style ops).
- Stall  in  1  1: hold A and B; register writes and PSR updates still occur.
- WrEn  in  1  write-back enable.
- WrAddr  in  4  write-back register index.
- WrData  in  16  write-back data (ALU C).
- FlagsEn  in  1  PSR update enable.
- FlagsIn  in  5  ALU flags {Z,C,F,N,L}, bit4=Z .. bit0=L.
- A  out  16  registered operand A to ALU.
- B  out  16  registered operand B to ALU.
- PSR  out  5  registered status flags, same bit order as FlagsIn.

Behaviour:
- Reset (reset_n=0 at rising clk): all NREGS registers=0, A=0, B=0, PSR=0. Reset dominates WrEn, FlagsEn and Stall. Reset mid-stall clears everything; Stall has no effect until reset_n=1.
- Write: at rising clk with WrEn=1, reg[WrAddr] <= WrData. If R0_ZERO=1 and WrAddr=0, the write is discarded.
- Operand latch, 1-cycle latency: at rising clk with Stall=0:
  - A <= rd(RdestAddr).
  - B <= ImmSel ? ext(Imm) : rd(RsrcAddr).
- rd(x) write-forward: if WrEn=1 and WrAddr=x, rd(x)=WrData (same-edge bypass, new value). Otherwise rd(x)=reg[x].
- R0_ZERO=1: rd(0)=0 always, with no bypass.
- ext(Imm): ImmSigned=1 gives {{8{Imm[7]}},Imm}; ImmSigned=0 gives {8'h00,Imm}.
- Stall=1: A and B hold their previous values. Writes and PSR updates proceed. The first cycle after Stall falls, A and B reflect register contents including every write made during the stall.
- Same register on both ports (RdestAddr=RsrcAddr, ImmSel=0): A and B both receive the same (forwarded) value.
- PSR: at rising clk with FlagsEn=1, PSR <= FlagsIn; otherwise PSR holds. It is independent of WrEn and Stall.
- Simultaneous WrEn and FlagsEn are legal and independent.
- Addresses are 4 bits with no out-of-range case. No X may propagate from unwritten registers because reset zeroes them.

Test Plan:
- Reset then read: reset_n=0 for 2 cycles, release. RdestAddr=5, RsrcAddr=9, ImmSel=0 -> A=0x0000, B=0x0000, PSR=5'b00000 after 1 clk.
- Write then read: WrEn=1, WrAddr=3, WrData=0x1234. Next cycle RdestAddr=3 -> A=0x1234 one clk later.
- Forwarding: same edge WrEn=1, WrAddr=7, WrData=0xBEEF with RsrcAddr=7, ImmSel=0 -> B=0xBEEF after that edge (not the old value 0x0000).
- Immediate extension: Imm=0xF0, ImmSel=1, ImmSigned=1 -> B=0xFFF0. With ImmSigned=0 -> B=0x00F0. RsrcAddr content is ignored in both cases.
- Stall: A=0x0011 latched, then Stall=1 for 3 cycles while writing reg[RdestAddr]=0x0022 -> A stays 0x0011. First clk after Stall=0 -> A=0x0022.
- PSR and R0_ZERO:
  - FlagsEn=1, FlagsIn=5'b10010 -> PSR=5'b10010. FlagsEn=0 with FlagsIn=5'b01101 -> PSR unchanged.
  - With R0_ZERO=1: write 0xAAAA to R0, then read R0 -> A=0x0000.
